// File: rtl/write_back_stage.sv
// MEM/WB write-back stage: one-cycle registered source select with sub-word
// load extraction, register-file write port and retired-instruction counter.
module write_back_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32,
  localparam int LSB_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  in_valid,
  input  logic                  in_reg_we,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [1:0]            in_sel,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [LSB_W-1:0]      in_addr_lsb,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] link_data,
  input  logic [DATA_WIDTH-1:0] imm_data,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  localparam int N_BYTES  = DATA_WIDTH / 8;
  localparam int N_HALVES = DATA_WIDTH / 16;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [7:0]            byte_field;
  logic [15:0]           half_field;
  logic [LSB_W-1:0]      half_lane;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] next_data;
  logic                  next_we;

  // Lane selection by comparison rather than a variable part-select, so an
  // offset beyond the last lane reads zero instead of going out of range.
  always_comb begin
    byte_field = '0;
    half_field = '0;
    half_lane  = in_addr_lsb >> 1;
    for (int unsigned i = 0; i < N_BYTES; i++) begin
      if (in_addr_lsb == LSB_W'(i))
        byte_field = mem_data[8*i +: 8];
    end
    for (int unsigned j = 0; j < N_HALVES; j++) begin
      if (half_lane == LSB_W'(j))
        half_field = mem_data[16*j +: 16];
    end
  end

  always_comb begin
    load_data = mem_data;
    case (in_size)
      SIZE_BYTE: begin
        load_data      = {DATA_WIDTH{~in_unsigned & byte_field[7]}};
        load_data[7:0] = byte_field;
      end
      SIZE_HALF: begin
        load_data       = {DATA_WIDTH{~in_unsigned & half_field[15]}};
        load_data[15:0] = half_field;
      end
      default: load_data = mem_data;
    endcase
  end

  always_comb begin
    next_data = imm_data;
    case (in_sel)
      SEL_ALU:  next_data = alu_data;
      SEL_MEM:  next_data = load_data;
      SEL_LINK: next_data = link_data;
      default:  next_data = imm_data;
    endcase
  end

  assign next_we = in_valid & in_reg_we & (in_rd != '0);

  // Flush wins over stall; the counter only moves on a real capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      retired_count <= '0;
    end else if (flush_i) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (!stall_i) begin
      wb_valid <= in_valid;
      wb_we    <= next_we;
      wb_rd    <= in_rd;
      wb_data  <= next_data;
      if (in_valid)
        retired_count <= retired_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage: a 32-bit instance and a 64-bit instance
// with a 4-bit counter share control inputs; expectations go through a queue.
module tb_write_back_stage;

  typedef struct {
    string       tag;
    bit          on_b;
    logic        valid;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [31:0] cnt;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, flush, valid, reg_we, uns;
  logic [4:0]  rd;
  logic [1:0]  sel, size;
  logic [2:0]  lsb;
  logic [63:0] alu, mem, link, imm;

  logic        a_valid, a_we;
  logic [4:0]  a_rd;
  logic [31:0] a_data, a_cnt;
  logic        b_valid, b_we;
  logic [4:0]  b_rd;
  logic [63:0] b_data;
  logic [3:0]  b_cnt;

  int errors = 0;
  int checks = 0;
  int unsigned cnt_a = 0;
  int unsigned cnt_b = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  write_back_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .in_valid(valid), .in_reg_we(reg_we), .in_rd(rd), .in_sel(sel),
    .in_size(size), .in_unsigned(uns), .in_addr_lsb(lsb[1:0]),
    .alu_data(alu[31:0]), .mem_data(mem[31:0]), .link_data(link[31:0]),
    .imm_data(imm[31:0]),
    .wb_valid(a_valid), .wb_we(a_we), .wb_rd(a_rd), .wb_data(a_data),
    .retired_count(a_cnt)
  );

  write_back_stage #(.DATA_WIDTH(64), .REG_ADDR_W(5), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .in_valid(valid), .in_reg_we(reg_we), .in_rd(rd), .in_sel(sel),
    .in_size(size), .in_unsigned(uns), .in_addr_lsb(lsb),
    .alu_data(alu), .mem_data(mem), .link_data(link), .imm_data(imm),
    .wb_valid(b_valid), .wb_we(b_we), .wb_rd(b_rd), .wb_data(b_data),
    .retired_count(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.on_b) begin
        check({e.tag, ".a.valid"}, 64'(a_valid), 64'(e.valid));
        check({e.tag, ".a.we"},    64'(a_we),    64'(e.we));
        check({e.tag, ".a.rd"},    64'(a_rd),    64'(e.rd));
        check({e.tag, ".a.data"},  64'(a_data),  e.data);
        check({e.tag, ".a.cnt"},   64'(a_cnt),   64'(e.cnt));
      end else begin
        check({e.tag, ".b.valid"}, 64'(b_valid), 64'(e.valid));
        check({e.tag, ".b.we"},    64'(b_we),    64'(e.we));
        check({e.tag, ".b.rd"},    64'(b_rd),    64'(e.rd));
        check({e.tag, ".b.data"},  b_data,       e.data);
        check({e.tag, ".b.cnt"},   64'(b_cnt),   64'(e.cnt));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic expect_a(input string tag, input logic v, input logic w,
                          input logic [4:0] r, input logic [63:0] d);
    exp_t e;
    e.tag = tag; e.on_b = 1'b0; e.valid = v; e.we = w; e.rd = r;
    e.data = {32'h0, d[31:0]}; e.cnt = 32'(cnt_a);
    sb.push_back(e);
  endtask

  task automatic expect_b(input string tag, input logic v, input logic w,
                          input logic [4:0] r, input logic [63:0] d);
    exp_t e;
    e.tag = tag; e.on_b = 1'b1; e.valid = v; e.we = w; e.rd = r;
    e.data = d; e.cnt = 32'(cnt_b);
    sb.push_back(e);
  endtask

  // Routes d to the selected source; other sources carry distinct filler.
  task automatic drive(input logic v, input logic w, input logic [4:0] r,
                       input logic [1:0] s, input logic [1:0] sz, input logic u,
                       input logic [2:0] l, input logic [63:0] d);
    valid = v; reg_we = w; rd = r; sel = s; size = sz; uns = u; lsb = l;
    alu  = 64'h1111_1111_1111_1111;
    mem  = 64'h2222_2222_2222_2222;
    link = 64'h3333_3333_3333_3333;
    imm  = 64'h4444_4444_4444_4444;
    case (s)
      2'b00:   alu  = d;
      2'b01:   mem  = d;
      2'b10:   link = d;
      default: imm  = d;
    endcase
  endtask

  task automatic count_capture();
    if (valid && !flush && !stall) begin
      cnt_a = cnt_a + 1;
      cnt_b = (cnt_b + 1) % 16;
    end
  endtask

  task automatic cap_a(input string tag, input logic v, input logic w,
                       input logic [4:0] r, input logic [1:0] s, input logic [1:0] sz,
                       input logic u, input logic [2:0] l, input logic [63:0] d,
                       input logic ev, input logic ewe, input logic [4:0] erd,
                       input logic [63:0] ed);
    drive(v, w, r, s, sz, u, l, d);
    count_capture();
    expect_a(tag, ev, ewe, erd, ed);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d;
    stall = 1'b0;
    flush = 1'b0;
    drive(0, 0, 5'd0, 2'b00, 2'b00, 0, 3'd0, 64'h0);

    // Reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'($urandom); reg_we = 1'($urandom); rd = 5'($urandom);
      sel = 2'($urandom); size = 2'($urandom); uns = 1'($urandom);
      lsb = 3'($urandom); stall = 1'($urandom); flush = 1'($urandom);
      alu = {$urandom, $urandom}; mem = {$urandom, $urandom};
      link = {$urandom, $urandom}; imm = {$urandom, $urandom};
      expect_a("reset", 0, 0, 5'd0, 64'h0);
      expect_b("reset", 0, 0, 5'd0, 64'h0);
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    cap_a("alu_basic", 1, 1, 5'd3, 2'b00, 2'b00, 0, 3'd0, 64'h1234_5678,
          1, 1, 5'd3, 64'h1234_5678);

    // Sub-word loads from 0x80FF7F01
    cap_a("ld_b2_s", 1, 1, 5'd5, 2'b01, 2'b00, 0, 3'd2, 64'h80FF_7F01, 1, 1, 5'd5, 64'hFFFF_FFFF);
    cap_a("ld_b3_u", 1, 1, 5'd5, 2'b01, 2'b00, 1, 3'd3, 64'h80FF_7F01, 1, 1, 5'd5, 64'h0000_0080);
    cap_a("ld_b1_s", 1, 1, 5'd5, 2'b01, 2'b00, 0, 3'd1, 64'h80FF_7F01, 1, 1, 5'd5, 64'h0000_007F);
    cap_a("ld_h3_s", 1, 1, 5'd5, 2'b01, 2'b01, 0, 3'd3, 64'h80FF_7F01, 1, 1, 5'd5, 64'hFFFF_80FF);
    cap_a("ld_h0_u", 1, 1, 5'd5, 2'b01, 2'b01, 1, 3'd0, 64'h80FF_7F01, 1, 1, 5'd5, 64'h0000_7F01);
    cap_a("ld_h1_s", 1, 1, 5'd5, 2'b01, 2'b01, 0, 3'd1, 64'h80FF_7F01, 1, 1, 5'd5, 64'h0000_7F01);
    cap_a("ld_w10",  1, 1, 5'd5, 2'b01, 2'b10, 0, 3'd2, 64'h80FF_7F01, 1, 1, 5'd5, 64'h80FF_7F01);
    cap_a("ld_w11",  1, 1, 5'd5, 2'b01, 2'b11, 1, 3'd3, 64'h80FF_7F01, 1, 1, 5'd5, 64'h80FF_7F01);
    cap_a("alu_size_ignored", 1, 1, 5'd7, 2'b00, 2'b00, 0, 3'd2, 64'hCAFE_F00D,
          1, 1, 5'd7, 64'hCAFE_F00D);
    cap_a("imm", 1, 1, 5'd8, 2'b11, 2'b00, 0, 3'd0, 64'hDEAD_0000, 1, 1, 5'd8, 64'hDEAD_0000);

    // r0 suppression, no-write and invalid entries
    cap_a("r0_write", 1, 1, 5'd0, 2'b00, 2'b00, 0, 3'd0, 64'h11, 1, 0, 5'd0, 64'h11);
    cap_a("no_reg_we", 1, 0, 5'd9, 2'b00, 2'b00, 0, 3'd0, 64'h22, 1, 0, 5'd9, 64'h22);
    cap_a("invalid", 0, 1, 5'd10, 2'b11, 2'b00, 0, 3'd0, 64'h33, 0, 0, 5'd10, 64'h33);

    // Stall and flush
    cap_a("link", 1, 1, 5'd31, 2'b10, 2'b00, 0, 3'd0, 64'h0000_0108, 1, 1, 5'd31, 64'h0000_0108);
    stall = 1'b1;
    for (int i = 0; i < 3; i++)
      cap_a("stall_hold", 1, 1, 5'd12, 2'b00, 2'b00, 0, 3'd0, 64'(32'hBAD0 + i),
            1, 1, 5'd31, 64'h0000_0108);
    flush = 1'b1;
    cap_a("stall_flush", 1, 1, 5'd13, 2'b00, 2'b00, 0, 3'd0, 64'h77, 0, 0, 5'd0, 64'h0);
    cap_a("resume_after_flush", 0, 0, 5'd1, 2'b00, 2'b00, 0, 3'd0, 64'h0, 0, 0, 5'd0, 64'h0);
    stall = 1'b0;
    cap_a("flush_only", 1, 1, 5'd14, 2'b00, 2'b00, 0, 3'd0, 64'h88, 0, 0, 5'd0, 64'h0);
    flush = 1'b0;
    cap_a("after_flush", 1, 1, 5'd15, 2'b11, 2'b00, 0, 3'd0, 64'h99, 1, 1, 5'd15, 64'h99);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    cnt_a = 0;
    cnt_b = 0;
    expect_a("async_reset", 0, 0, 5'd0, 64'h0);
    expect_b("async_reset", 0, 0, 5'd0, 64'h0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap on the 4-bit instance, with non-counting captures mixed in
    for (int i = 0; i < 17; i++) begin
      if (i == 8) begin
        drive(0, 1, 5'd20, 2'b00, 2'b00, 0, 3'd0, 64'h5);
        count_capture();
        expect_b("wrap_invalid", 0, 0, 5'd20, 64'h5);
        tick();
        flush = 1'b1;
        drive(1, 1, 5'd21, 2'b00, 2'b00, 0, 3'd0, 64'h6);
        count_capture();
        expect_b("wrap_flushed", 0, 0, 5'd0, 64'h0);
        tick();
        flush = 1'b0;
      end
      d = {32'(i) ^ 32'hA5A5_0000, 32'(i)};
      drive(1, 1, 5'(i + 1), 2'b00, 2'b00, 0, 3'd0, d);
      count_capture();
      expect_a("wrap_step", 1, 1, 5'(i + 1), d);
      expect_b("wrap_step", 1, 1, 5'(i + 1), d);
      tick();
    end
    check("wrap_final_b", 64'(b_cnt), 64'd1);
    check("wrap_final_a", 64'(a_cnt), 64'd17);

    // 64-bit extraction at the top lanes
    drive(1, 1, 5'd6, 2'b01, 2'b00, 0, 3'd7, 64'hAB00_0000_0000_0000);
    count_capture();
    expect_b("w64_b7_s", 1, 1, 5'd6, 64'hFFFF_FFFF_FFFF_FFAB);
    expect_a("w32_b3_zero", 1, 1, 5'd6, 64'h0);
    tick();
    drive(1, 1, 5'd6, 2'b01, 2'b00, 1, 3'd7, 64'hAB00_0000_0000_0000);
    count_capture();
    expect_b("w64_b7_u", 1, 1, 5'd6, 64'h0000_0000_0000_00AB);
    tick();
    drive(1, 1, 5'd6, 2'b01, 2'b01, 0, 3'd7, 64'hAB00_0000_0000_0000);
    count_capture();
    expect_b("w64_h3_s", 1, 1, 5'd6, 64'hFFFF_FFFF_FFFF_AB00);
    tick();
    drive(1, 1, 5'd6, 2'b01, 2'b01, 1, 3'd6, 64'hAB00_0000_0000_0000);
    count_capture();
    expect_b("w64_h3_u", 1, 1, 5'd6, 64'h0000_0000_0000_AB00);
    tick();
    drive(1, 1, 5'd6, 2'b01, 2'b10, 0, 3'd5, 64'hAB00_0000_0000_0000);
    count_capture();
    expect_b("w64_word", 1, 1, 5'd6, 64'hAB00_0000_0000_0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
